// File: rtl/div_secuencial_ctrl.sv
// div_secuencial_ctrl: multi-cycle restoring divider controller.
// Takes an unsigned N-bit dividend/divisor pair over a valid/ready handshake,
// produces one quotient bit per clock (MSB first) with one shared (N+1)-bit
// subtractor, and offers the result over a second valid/ready handshake.
// Optional build macro DIV_ZERO_FLAG_EN: a zero divisor short-circuits the
// iteration and raises dz. Without it, dz is tied low and a zero divisor
// simply runs the normal iteration (which yields Q = all ones, R = A).
module div_secuencial_ctrl #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         dz,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N:0]    rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;

  logic [N:0]    r_sig;
  logic [N:0]    diff;
  logic          take;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;

`ifdef DIV_ZERO_FLAG_EN
  logic          zero_q;
  logic          dz_q;
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  // One restoring step: a_q is shifted left every cycle so its MSB is always
  // the next dividend bit; quo shifts the new bit in at the LSB so that after
  // N steps the first bit produced sits at the MSB.
  always_comb begin
    r_sig    = {rem[N-1:0], a_q[N-1]};
    diff     = r_sig - {1'b0, b_q};
    take     = ~diff[N];
    rem_next = take ? diff : r_sig;
    quo_next = {quo[N-2:0], take};
  end

  // Controller FSM with all handshake flags and results held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Q         <= '0;
      R         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
`ifdef DIV_ZERO_FLAG_EN
      zero_q    <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            rem      <= '0;
            quo      <= '0;
            cnt      <= CW'(N - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
`ifdef DIV_ZERO_FLAG_EN
            zero_q   <= (B == '0);
            dz_q     <= 1'b0;
`endif
          end
        end

        BUSY: begin
`ifdef DIV_ZERO_FLAG_EN
          // A zero divisor spends a single cycle here and skips the iteration;
          // a_q has not been shifted yet so it still holds the dividend.
          if (zero_q) begin
            Q         <= '1;
            R         <= a_q;
            dz_q      <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else
`endif
          begin
            a_q <= a_q << 1;
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == '0) begin
              Q         <= quo_next;
              R         <= rem_next[N-1:0];
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_secuencial_ctrl.sv
// tb_div_secuencial_ctrl: self-checking bench for div_secuencial_ctrl.
// Instantiates an N=4 and an N=8 divider sharing clock and reset; sel8 picks
// which one the stimulus tasks drive and observe. Expected results come from
// plain integer division, with B==0 handled by the documented rules.
module tb_div_secuencial_ctrl;

`ifdef DIV_ZERO_FLAG_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       sel8;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       ir4, ov4, dz4, busy4;
  logic [3:0] q4, r4;
  logic       ir8, ov8, dz8, busy8;
  logic [7:0] q8, r8;

  logic       in_ready_s, out_valid_s, dz_s, busy_s;
  logic [7:0] q_s, r_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_secuencial_ctrl #(.N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel8),
    .in_ready  (ir4),
    .A         (a_in[3:0]),
    .B         (b_in[3:0]),
    .out_valid (ov4),
    .out_ready (out_ready),
    .Q         (q4),
    .R         (r4),
    .dz        (dz4),
    .busy      (busy4)
  );

  div_secuencial_ctrl #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel8),
    .in_ready  (ir8),
    .A         (a_in),
    .B         (b_in),
    .out_valid (ov8),
    .out_ready (out_ready),
    .Q         (q8),
    .R         (r8),
    .dz        (dz8),
    .busy      (busy8)
  );

  assign in_ready_s  = sel8 ? ir8   : ir4;
  assign out_valid_s = sel8 ? ov8   : ov4;
  assign dz_s        = sel8 ? dz8   : dz4;
  assign busy_s      = sel8 ? busy8 : busy4;
  assign q_s         = sel8 ? q8    : {4'b0, q4};
  assign r_s         = sel8 ? r8    : {4'b0, r4};

  // One full transaction on the selected instance. hold = cycles of out_ready
  // low after the result appears (with a stray in_valid pulse in that window);
  // noise = keep in_valid high with changing operands while the divider works.
  task automatic run_op(input bit w8, input int a_arg, input int b_arg,
                        input int hold, input bit noise);
    int mask, a, b, exp_q, exp_r, lat, cyc;
    bit exp_dz;
    logic [7:0] eq, er;
    mask   = w8 ? 255 : 15;
    a      = a_arg & mask;
    b      = b_arg & mask;
    exp_q  = (b == 0) ? mask : a / b;
    exp_r  = (b == 0) ? a : a % b;
    exp_dz = FEAT && (b == 0);
    lat    = (FEAT && (b == 0)) ? 1 : (w8 ? 8 : 4);
    eq     = exp_q[7:0];
    er     = exp_r[7:0];

    sel8      = w8;
    out_ready = (hold == 0);
    cyc = 0;
    while (!in_ready_s && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (in_ready_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_ready_wait a=%0d b=%0d: got %b want 1", a, b, in_ready_s);
      return;
    end

    a_in     = a[7:0];
    b_in     = b[7:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = noise;

    checks++;
    if (in_ready_s !== 1'b0 || (lat > 1 && busy_s !== 1'b1)) begin
      errors++;
      $display("[TB] FAIL accept_flags a=%0d b=%0d: got in_ready=%b busy=%b want 0/1",
               a, b, in_ready_s, busy_s);
    end

    cyc = 0;
    while (!out_valid_s && cyc < 40) begin
      if (noise) begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;

    checks++;
    if (out_valid_s !== 1'b1 || cyc != lat) begin
      errors++;
      $display("[TB] FAIL latency a=%0d b=%0d: got %0d cycles (out_valid=%b) want %0d",
               a, b, cyc, out_valid_s, lat);
    end

    checks++;
    if (q_s !== eq || r_s !== er || dz_s !== exp_dz) begin
      errors++;
      $display("[TB] FAIL result a=%0d b=%0d: got Q=%0d R=%0d dz=%b want Q=%0d R=%0d dz=%b",
               a, b, q_s, r_s, dz_s, eq, er, exp_dz);
    end

    if (hold > 0) begin
      a_in     = 8'($urandom);
      b_in     = 8'd1;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || q_s !== eq ||
            r_s !== er || dz_s !== exp_dz) begin
          errors++;
          $display("[TB] FAIL hold_stable cyc=%0d: got ov=%b ir=%b Q=%0d R=%0d dz=%b want ov=1 ir=0 Q=%0d R=%0d dz=%b",
                   i, out_valid_s, in_ready_s, q_s, r_s, dz_s, eq, er, exp_dz);
        end
      end
      out_ready = 1'b1;
    end

    @(negedge clk);
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_handshake a=%0d b=%0d: got out_valid=%b in_ready=%b want 0/1",
               a, b, out_valid_s, in_ready_s);
    end
  endtask

  // Checks the reset values on whichever instance sel8 currently selects.
  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || busy_s !== 1'b0 ||
        q_s !== 8'd0 || r_s !== 8'd0 || dz_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s sel8=%b: got ir=%b ov=%b busy=%b Q=%0d R=%0d dz=%b want 1 0 0 0 0 0",
               tag, sel8, in_ready_s, out_valid_s, busy_s, q_s, r_s, dz_s);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel8 = s[0];
      #1;
      check_reset_values("reset_state");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel8 = s[0];
      #1;
      check_reset_values("after_release");
    end
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    run_op(1'b0, 13, 3, 0, 1'b0);
    run_op(1'b0, 2, 7, 0, 1'b0);
    run_op(1'b0, 15, 1, 0, 1'b0);
    run_op(1'b0, 9, 9, 0, 1'b0);
    run_op(1'b0, 0, 5, 0, 1'b0);
  endtask

  task automatic test_div_zero();
    $display("[TB] test_div_zero");
    run_op(1'b0, 11, 0, 0, 1'b0);
    run_op(1'b0, 6, 2, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    run_op(1'b0, 14, 4, 6, 1'b0);
  endtask

  task automatic test_in_valid_held();
    $display("[TB] test_in_valid_held");
    run_op(1'b0, 13, 3, 0, 1'b1);
    run_op(1'b1, 200, 7, 3, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    $display("[TB] test_reset_mid_op");
    sel8      = 1'b0;
    out_ready = 1'b1;
    a_in      = 8'd12;
    b_in      = 8'd5;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset_mid_busy");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 7, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    int a, b;
    $display("[TB] test_random");
    run_op(1'b1, 255, 255, 0, 1'b0);
    run_op(1'b1, 255, 1, 0, 1'b0);
    run_op(1'b1, 0, 200, 0, 1'b0);
    run_op(1'b1, 77, 0, 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
      run_op(1'b1, a, b, (i % 50 == 0) ? 2 : 0, 1'b0);
    end
  endtask

  // Top-level sequence of scenarios followed by the summary line.
  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel8      = 1'b0;
    a_in      = 8'd0;
    b_in      = 8'd0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_in_valid_held();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_secuencial_ctrl.md
Name: div_secuencial_ctrl

Overview:
Multi-cycle restoring divider controller. It accepts an unsigned N-bit dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per clock, MSB first. Each step uses a single shared (N+1)-bit subtractor. The result is presented over a second valid/ready handshake. This is the sequential, area-reduced counterpart of the team's combinational unrolled divider, for integration where an N-stage subtractor chain does not meet timing.

Parameters:
N, 4, operand/quotient/remainder width in bits (N >= 2)
CW, $clog2(N+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
A  input  N  dividend, sampled on input handshake
B  input  N  divisor, sampled on input handshake
out_valid  output  1  Q/R/dz valid
out_ready  input  1  consumer accepts result
Q  output  N  quotient
R  output  N  remainder
dz  output  1  divide-by-zero flag (see Optional Feature)
busy  output  1  high in BUSY state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1, out_valid=0, busy=0, Q=0, R=0, dz=0; counter, latched operands and partial remainder cleared. Release takes effect on the next rising edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A into shift register a_q and B into b_q; clear rem (N+1 bits) and quo; cnt=N-1; go to BUSY.
- BUSY, each cycle:
  - r_sig = {rem[N-1:0], a_q[cnt]}.
  - d = r_sig - {1'b0,b_q}, (N+1)-bit.
  - If d[N]=1: quo[cnt]=0, rem=r_sig.
  - Else: quo[cnt]=1, rem=d.
  - If cnt==0, go to DONE; else cnt--.
  - Exactly N BUSY cycles.
  - in_ready=0; in_valid is ignored and must not disturb latched operands.
- DONE:
  - out_valid=1; Q=quo, R=rem[N-1:0], dz per feature.
  - Outputs held stable while out_ready=0, for any duration.
  - On out_valid&out_ready, go to IDLE; out_valid deasserts the following cycle.
- Latency: input handshake at edge k gives out_valid=1 after edge k+N.
- Throughput: one operation per N+2 cycles minimum. in_ready is low in DONE, so no back-to-back overlap.
- Q/R registered. Values outside DONE are don't-care for checking; the implementation holds the last result.
- Arithmetic: unsigned only. Results satisfy A == Q*B + R with R < B for B != 0.
- Boundary conditions:
  - A < B: Q=0, R=A.
  - A=0: Q=0, R=0.
  - B=1: Q=A, R=0.
  - A=B: Q=1, R=0.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the in-flight operation is discarded and no out_valid is produced for it.
- in_valid held high after acceptance: not re-accepted until the controller returns to IDLE.

Optional Feature:
DIV_ZERO_FLAG_EN
- Defined:
  - Input handshake with B==0 skips BUSY and goes directly to DONE on the next edge (latency 1).
  - Result: Q='1 (all ones), R=A, dz=1.
  - dz=0 for all nonzero divisors; dz is cleared on every new acceptance.
- Undefined:
  - B==0 runs the normal N-cycle iteration, which naturally yields Q='1 and R=A.
  - dz is tied to 0.
  - The port stays present in both builds.

Test Plan:
- N=4, A=13, B=3, out_ready=1 -> out_valid exactly 4 cycles after accept, Q=4, R=1; then in_ready=1 one cycle after output handshake.
- N=4, A=2, B=7 -> Q=0, R=2; A=15, B=1 -> Q=15, R=0; A=9, B=9 -> Q=1, R=0.
- N=4, A=11, B=0:
  - With DIV_ZERO_FLAG_EN: out_valid 1 cycle after accept, Q=15, R=11, dz=1.
  - Without: out_valid after 4 cycles, Q=15, R=11, dz=0.
- Backpressure: A=14, B=4 with out_ready=0 for 6 cycles -> Q=3, R=2 held stable with out_valid high throughout. A new in_valid pulse in that window is not accepted.
- Reset mid-operation: accept A=12, B=5, assert rst_n low after 2 BUSY cycles -> all outputs return to reset values asynchronously. After release, A=7, B=2 -> Q=3, R=1 with no stale result.
- N=8, 1000 random pairs plus the corners A=255/B=255, A=255/B=1, A=0/B=200 -> every result matches A/B and A%B; latency always 8 (or 1 for B=0 with the feature enabled).
